// File: rtl/l2_req_arbiter_pkg.sv
// Shared L2 request arbiter definitions: FSM states, owner ids, direction and
// enable encodings, and the I-cache win rule used during arbitration.
package l2_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // D-cache wins by default; the I-cache wins when alone or once starved.
  function automatic logic ic_wins(input logic ic_req, input logic dc_req,
                                   input logic starve_hit);
    return ic_req && (!dc_req || starve_hit);
  endfunction

endpackage

// File: rtl/l2_req_arbiter_if.sv
// L1 I/D miss request and L2 issue bundle seen by the L2 request arbiter.
interface l2_req_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_grant;
  logic              ic_done;
  logic              dc_req;
  logic [ADDR_W-1:0] dc_addr;
  logic              dc_rw;
  logic              dc_grant;
  logic              dc_done;
  logic              l2_req;
  logic [ADDR_W-1:0] l2_addr;
  logic              l2_rw;
  logic              l2_busy;
  logic              l2_done;
  logic              owner;

  // Arbiter side.
  modport slave (
    input  ic_req, ic_addr, dc_req, dc_addr, dc_rw, l2_busy, l2_done,
    output ic_grant, ic_done, dc_grant, dc_done, l2_req, l2_addr, l2_rw, owner
  );

  // Requester / L2 side.
  modport master (
    output ic_req, ic_addr, dc_req, dc_addr, dc_rw, l2_busy, l2_done,
    input  ic_grant, ic_done, dc_grant, dc_done, l2_req, l2_addr, l2_rw, owner
  );
endinterface

// File: rtl/l2_arb_starve_ctr.sv
// Saturating count of consecutive D-cache wins while the I-cache waits;
// starve_hit forces the next arbitration to the I-cache.
module l2_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic ic_req,
  input  logic ic_win,
  output logic starve_hit
);
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;

  // Only moves on arbitration cycles; an I grant or an idle I-cache clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (!ic_req || ic_win)
        starve_cnt <= '0;
      else if (starve_cnt != CNT_MAX)
        starve_cnt <= starve_cnt + CW'(1);
    end
  end

  assign starve_hit = (starve_cnt == CNT_MAX);

endmodule

// File: rtl/l2_req_arbiter.sv
// Two-requester (L1 I/D) arbiter for the shared L2: picks a winner, latches
// its address/direction, issues one L2 request and holds ownership until
// L2 completes, then pulses the owner's done.
module l2_req_arbiter
  import l2_req_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  l2_req_arbiter_if.slave  bus
);
  arb_state_e        state, state_nxt;
  logic              owner_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic              any_req, arb_en, ic_win, starve_hit;
  logic              grant_c, done_c, l2_req_c;

  assign any_req = bus.ic_req | bus.dc_req;
  assign arb_en  = (state == ARB_IDLE) && any_req;
  assign ic_win  = ic_wins(bus.ic_req, bus.dc_req, starve_hit);

  l2_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk        (clk),
    .rst        (rst),
    .arb_en     (arb_en),
    .ic_req     (bus.ic_req),
    .ic_win     (ic_win),
    .starve_hit (starve_hit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-state grant/done/issue strobes. l2_done is only
  // looked at in WAIT, so a done coincident with the issue pulse is ignored.
  always_comb begin
    state_nxt = state;
    grant_c   = DISABLE;
    done_c    = DISABLE;
    l2_req_c  = DISABLE;
    case (state)
      ARB_IDLE: begin
        if (any_req) state_nxt = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        grant_c = ENABLE;
        if (!bus.l2_busy) begin
          l2_req_c  = ENABLE;
          state_nxt = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        grant_c = ENABLE;
        if (bus.l2_done) state_nxt = ARB_DONE;
      end
      ARB_DONE: begin
        done_c    = ENABLE;
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Winner's request is captured once at arbitration and held until the
  // next one; later changes on the L1 inputs are not sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWNER_IC;
      rw_q    <= READ;
      addr_q  <= '0;
    end else if (arb_en) begin
      owner_q <= ic_win ? OWNER_IC : OWNER_DC;
      addr_q  <= ic_win ? bus.ic_addr : bus.dc_addr;
      rw_q    <= (!ic_win && bus.dc_rw == WRITE) ? WRITE : READ;
    end
  end

  assign bus.ic_grant = grant_c && (owner_q == OWNER_IC);
  assign bus.dc_grant = grant_c && (owner_q == OWNER_DC);
  assign bus.ic_done  = done_c  && (owner_q == OWNER_IC);
  assign bus.dc_done  = done_c  && (owner_q == OWNER_DC);
  assign bus.l2_req   = l2_req_c;
  assign bus.l2_addr  = addr_q;
  assign bus.l2_rw    = rw_q;
  assign bus.owner    = owner_q;

endmodule
